// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - packet-granular N:1 arbiter with registered output stage
// Define PACKET_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module packet_arbiter #(
    parameter int WIDTH  = 8,
    parameter int INPUTS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [INPUTS-1:0]       valid_i,
    output logic [INPUTS-1:0]       ready_o,
    input  logic [INPUTS-1:0]       last_i,
    input  logic [INPUTS*WIDTH-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    last_o,
    output logic [WIDTH-1:0]        data_o,
    output logic [INPUTS-1:0]       grant_o,
    output logic                    busy_o
);

    localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  owner, owner_next, winner;
    logic [INPUTS-1:0] grant, grant_next;
    logic              any_valid;
    logic              accept_ok;
    logic              req_xfer;
    logic              out_xfer;
    logic              out_valid;
    logic              out_last;
    logic [WIDTH-1:0]  out_data;
    logic [WIDTH-1:0]  owner_data;

    assign any_valid = |valid_i;

`ifdef PACKET_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Cyclic search starting one past the previous winner.
    always_comb begin
        winner = last_winner;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= INPUTS; i++) begin
            cand = IDX_W'((int'(last_winner) + i) % INPUTS);
            if (!found && valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_winner <= IDX_W'(INPUTS - 1);
        end else if (state == IDLE && any_valid) begin
            last_winner <= winner;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (valid_i[IDX_W'(i)]) begin
                winner = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        owner_data = '0;
        for (int n = 0; n < INPUTS; n++) begin
            if (owner == IDX_W'(n)) begin
                owner_data = data_i[n*WIDTH +: WIDTH];
            end
        end
    end

    // Accept gating also covers reset so no requester beat is lost into a register being cleared.
    assign accept_ok = (!out_valid || ready_i) && !reset;

    always_comb begin
        state_next = state;
        owner_next = owner;
        grant_next = grant;
        ready_o    = '0;
        req_xfer   = 1'b0;
        case (state)
            IDLE: begin
                grant_next = '0;
                if (any_valid) begin
                    state_next = BUSY;
                    owner_next = winner;
                    grant_next = {{(INPUTS-1){1'b0}}, 1'b1} << winner;
                end
            end
            BUSY: begin
                ready_o[owner] = accept_ok;
                req_xfer       = valid_i[owner] && accept_ok;
                if (req_xfer && last_i[owner]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            grant <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            grant <= grant_next;
        end
    end

    // Output stage drains on its own, regardless of arbiter state.
    assign out_xfer = valid_o && ready_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (req_xfer) begin
            out_valid <= 1'b1;
            out_last  <= last_i[owner];
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (req_xfer) begin
            out_data <= owner_data;
        end
    end

    assign valid_o = out_valid && !reset;
    assign last_o  = out_last && !reset;
    assign data_o  = out_data;
    assign grant_o = reset ? '0 : grant;
    assign busy_o  = (state == BUSY) && !reset;

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - scoreboard bench for packet_arbiter
module tb_packet_arbiter;

    localparam int WIDTH  = 8;
    localparam int INPUTS = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        valid_i, ready_o, last_i, grant_o;
    logic [31:0]       data_i;
    logic              valid_o, ready_i, last_o, busy_o;
    logic [7:0]        data_o;

    logic              req_valid [4];
    logic              req_last  [4];
    logic [7:0]        req_data  [4];

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int owner;
        int cyc;
    } glog_t;

    beat_t sb [$];
    glog_t glog [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef PACKET_ARBITER_ROUND_ROBIN_EN
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    int exp_order [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
`endif

    packet_arbiter #(.WIDTH(WIDTH), .INPUTS(INPUTS)) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .last_i  (last_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .data_o  (data_o),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    always_comb begin
        valid_i = {req_valid[3], req_valid[2], req_valid[1], req_valid[0]};
        last_i  = {req_last[3], req_last[2], req_last[1], req_last[0]};
        data_i  = {req_data[3], req_data[2], req_data[1], req_data[0]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int owner_of(input logic [3:0] g);
        owner_of = -1;
        for (int i = 0; i < 4; i++) begin
            if (g[2'(i)]) owner_of = i;
        end
    endfunction

    // Drives one packet; called just after a rising edge.
    task automatic send(input logic [1:0] p, input int n, input logic [7:0] base);
        int  budget;
        logic accepted;
        for (int b = 0; b < n; b++) begin
            req_valid[p] = 1'b1;
            req_data[p]  = base + 8'(b);
            req_last[p]  = (b == n - 1);
            accepted     = 1'b0;
            budget       = 200;
            while (!accepted && budget > 0) begin
                @(negedge clock);
                if (ready_o[p]) accepted = 1'b1;
                else budget = budget - 1;
            end
            if (!accepted) begin
                fail_now("send_timeout");
                return;
            end
            sb.push_back('{data: req_data[p], last: req_last[p]});
            @(posedge clock);
            #1;
        end
        req_valid[p] = 1'b0;
        req_last[p]  = 1'b0;
    endtask

    task automatic send_two(input logic [1:0] p);
        for (int k = 0; k < 2; k++) begin
            send(p, 1, 8'(int'(p) * 16 + k));
        end
    endtask

    // Monitor: scoreboard pops plus per-cycle handshake invariants.
    initial begin
        beat_t       e;
        logic [3:0]  prev_grant;
        prev_grant = '0;
        forever begin
            @(negedge clock);
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_checks = n_checks + 1;
                    n_fail   = n_fail + 1;
                    $display("FAIL unexpected_beat: got data %0h, expected none", data_o);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 32'(data_o), 32'(e.data));
                    check("beat_last", 32'(last_o), 32'(e.last));
                end
            end
            if (busy_o) check("ready_only_owner", 32'(ready_o & ~grant_o), 32'h0);
            if (valid_o && !ready_i) check("ready_stall", 32'(ready_o), 32'h0);
            if (grant_o != 4'b0 && prev_grant == 4'b0) begin
                glog.push_back('{owner: owner_of(grant_o), cyc: cyc});
            end
            prev_grant = grant_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_data[i]  = 8'h00;
        end
        ready_i = 1'b1;
        reset   = 1'b1;
        tick(2);
        @(negedge clock);
        check("rst_valid_o", 32'(valid_o), 32'h0);
        check("rst_last_o",  32'(last_o),  32'h0);
        check("rst_busy_o",  32'(busy_o),  32'h0);
        check("rst_grant_o", 32'(grant_o), 32'h0);
        check("rst_ready_o", 32'(ready_o), 32'h0);

        // Requester 1, 3 beats, first arbitration right after reset falls.
        tick(1);
        reset = 1'b0;
        fork
            send(2'd1, 3, 8'hA0);
            begin
                @(negedge clock);
                check("t1_grant_idle", 32'(grant_o), 32'h0);
                check("t1_valid_idle", 32'(valid_o), 32'h0);
                @(negedge clock);
                check("t1_grant", 32'(grant_o), 32'h2);
                check("t1_busy",  32'(busy_o),  32'h1);
                check("t1_ready", 32'(ready_o), 32'h2);
                @(negedge clock);
                check("t1_first_valid", 32'(valid_o), 32'h1);
                check("t1_last_a", 32'(last_o), 32'h0);
                @(negedge clock);
                check("t1_last_b", 32'(last_o), 32'h0);
                @(negedge clock);
                check("t1_last_c", 32'(last_o), 32'h1);
                check("t1_busy_end", 32'(busy_o), 32'h0);
                check("t1_grant_end", 32'(grant_o), 32'h0);
                @(negedge clock);
                check("t1_drained", 32'(valid_o), 32'h0);
            end
        join
        tick(2);
        check("t1_sb_empty", 32'(sb.size()), 32'h0);

        // Requester 0 waits behind requester 2's packet.
        glog.delete();
        fork
            send(2'd2, 4, 8'h20);
            begin
                tick(2);
                send(2'd0, 1, 8'h01);
            end
        join
        tick(3);
        check("t2_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("t2_first_owner",  32'(glog[0].owner), 32'd2);
            check("t2_second_owner", 32'(glog[1].owner), 32'd0);
            check("t2_gap", 32'(glog[1].cyc - glog[0].cyc), 32'd5);
        end
        check("t2_sb_empty", 32'(sb.size()), 32'h0);

        // 10-beat packet with downstream ready toggling every cycle.
        fork
            send(2'd1, 10, 8'h50);
            begin
                for (int k = 0; k < 40; k++) begin
                    ready_i = (k % 2 == 0);
                    tick(1);
                end
                ready_i = 1'b1;
            end
        join
        tick(3);
        check("t3_sb_empty", 32'(sb.size()), 32'h0);

        // Reset pulse after the second beat of a 5-beat packet.
        glog.delete();
        fork
            send(2'd3, 5, 8'h30);
            begin
                tick(3);
                reset = 1'b1;
                sb.delete();
                @(negedge clock);
                check("t4_rst_valid", 32'(valid_o), 32'h0);
                check("t4_rst_ready", 32'(ready_o), 32'h0);
                tick(1);
                reset = 1'b0;
                @(negedge clock);
                check("t4_valid", 32'(valid_o), 32'h0);
                check("t4_grant", 32'(grant_o), 32'h0);
                check("t4_busy",  32'(busy_o),  32'h0);
                @(negedge clock);
                check("t4_regrant", 32'(grant_o), 32'h8);
            end
        join
        tick(4);
        check("t4_sb_empty", 32'(sb.size()), 32'h0);

        // All four requesters, two 1-beat packets each.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        glog.delete();
        fork
            send_two(2'd0);
            send_two(2'd1);
            send_two(2'd2);
            send_two(2'd3);
        join
        tick(4);
        check("t5_grants", 32'(glog.size()), 32'd8);
        if (glog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t5_owner", 32'(glog[i].owner), 32'(exp_order[i]));
                if (i > 0) check("t5_gap", 32'(glog[i].cyc - glog[i-1].cyc), 32'd2);
            end
        end
        check("t5_sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
